// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, register map and STATUS bit layout.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  localparam logic [31:0] DATA_OFF   = 32'd4;
  localparam logic [31:0] STATUS_OFF = 32'd8;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Load-path bus between the core and the UART receiver, plus the receive interrupt.
interface uart_rx_mmio_if;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] read_data;
  logic        rx_irq;

  modport master (output read_enable, output address, input read_data, input rx_irq);
  modport slave  (input read_enable, input address, output read_data, output rx_irq);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; a pop in the same cycle frees a slot for a push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with receive FIFO and DATA/STATUS registers.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors in STATUS bit 4.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_rx_mmio_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  rx_state_e            state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [BIT_W-1:0]     bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 push;
  logic                 frame_err_set;
  logic                 parity_err_set;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_head;
  logic                 is_data;
  logic                 is_status;
  logic                 pop;
  logic                 stat_clr;
  logic                 overrun_set;
  logic                 overrun;
  logic                 frame_err;
  logic                 parity_err;
  logic                 irq_q;
  logic [31:0]          status_word;

  // Synchroniser: idle-high reset so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    bit_nx         = bit_cnt;
    shift_nx       = shift;
    push           = 1'b0;
    frame_err_set  = 1'b0;
    parity_err_set = 1'b0;
    case (state)
      S_IDLE: begin
        // Edge-triggered start: a held-low break line never re-arms the receiver.
        if (rx_prev && !rx_s) begin
          state_nx = S_START;
          cnt_nx   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_nx   = '0;
          bit_nx   = '0;
          state_nx = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nx   = '0;
          shift_nx = {rx_s, shift[DATA_BITS-1:1]};
          bit_nx   = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_nx         = '0;
          parity_err_set = (rx_s != ^shift);
          state_nx       = S_STOP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nx        = '0;
          push          = rx_s;
          frame_err_set = !rx_s;
          state_nx      = S_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Register decode
  assign is_data     = (bus.address == BASE_ADDR + DATA_OFF);
  assign is_status   = (bus.address == BASE_ADDR + STATUS_OFF);
  assign pop         = bus.read_enable && is_data && !fifo_empty;
  assign stat_clr    = bus.read_enable && is_status;
  assign overrun_set = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      // A new error in the clearing cycle must not be lost.
      overrun    <= overrun_set    || (overrun    && !stat_clr);
      frame_err  <= frame_err_set  || (frame_err  && !stat_clr);
      parity_err <= parity_err_set || (parity_err && !stat_clr);
      irq_q      <= !fifo_empty;
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[ST_NOT_EMPTY]  = !fifo_empty;
    status_word[ST_FULL]       = fifo_full;
    status_word[ST_OVERRUN]    = overrun;
    status_word[ST_FRAME_ERR]  = frame_err;
    status_word[ST_PARITY_ERR] = parity_err;
  end

  always_comb begin
    bus.read_data = '0;
    if (is_data && !fifo_empty) bus.read_data = {24'b0, fifo_head};
    else if (is_status)         bus.read_data = status_word;
  end

  assign bus.rx_irq = irq_q;

endmodule
